// File: rtl/terminate_ctrl.sv
// terminate_ctrl: drain-window termination controller with cycle-budget watchdog.
// Define TERMINATE_CTRL_FINISH_EN to print the cause and call $finish one edge after DONE.
module terminate_ctrl #(
    parameter int DRAIN_CYCLES    = 16,
    parameter int WATCHDOG_CYCLES = 1000000,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             activity,
    output logic             done,
    output logic             timeout,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cycle_count
);
    localparam int DW = DRAIN_CYCLES > 0 ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [DW-1:0] DRAIN_LD = DW'(DRAIN_CYCLES);
    // a budget the counter can never reach is treated as disabled
    localparam logic WD_EN = WATCHDOG_CYCLES > 0 && (64'(WATCHDOG_CYCLES) >> CNT_W) == 64'd0;
    localparam logic [CNT_W-1:0] WD_VAL = CNT_W'(WATCHDOG_CYCLES);

    typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;

    state_t st, st_n;
    logic [DW-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] cc_n;
    logic to_n, wd_hit;

    always_comb begin
        cc_n = &cycle_count ? cycle_count : cycle_count + 1'b1;
        wd_hit = WD_EN && cc_n == WD_VAL;
        st_n = st;
        cnt_n = cnt;
        to_n = timeout;
        case (st)
            RUN: if (a) begin
                st_n = DRAIN;
                cnt_n = DRAIN_LD;
            end
            DRAIN: if (activity) cnt_n = DRAIN_LD;
                   else if (cnt == '0) st_n = DONE;
                   else cnt_n = cnt - 1'b1;
            default: ;
        endcase
        // graceful completion already selected DONE, so the watchdog only claims the remaining cases
        if (st != DONE && st_n != DONE && wd_hit) begin
            st_n = DONE;
            to_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= RUN;
            cnt <= '0;
            cycle_count <= '0;
            timeout <= 1'b0;
        end else begin
            st <= st_n;
            cnt <= cnt_n;
            timeout <= to_n;
            if (st != DONE) cycle_count <= cc_n;
        end
    end

    assign state = st;
    assign done = st == DONE;

`ifdef TERMINATE_CTRL_FINISH_EN
    logic fin;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fin <= 1'b0;
        else begin
            if (st != DONE && st_n == DONE)
                $display("[t=%0t] terminate: %s cycles=%0d", $time, to_n ? "timeout" : "graceful", cc_n);
            fin <= st != DONE && st_n == DONE;
            if (fin) $finish;
        end
    end
`endif
endmodule

// File: tb/tb_terminate_ctrl.sv
// tb_terminate_ctrl: four parameterisations of terminate_ctrl sharing one stimulus stream, each checked against a counting model.
module tb_terminate_ctrl;
    logic clk = 1'b0, rst = 1'b0, a = 1'b0, activity = 1'b0;
    logic [1:0] st_o[4];
    logic dn_o[4], to_o[4];
    logic [31:0] cc_o[4];
    logic [31:0] cc0, cc1;
    logic [7:0] cc2;
    logic [3:0] cc3;
    int vec = 0, miss = 0;

    int     P_D[4]   = '{4, 3, 0, 2};
    longint P_WD[4]  = '{0, 10, 23, 1000000};
    longint P_MAX[4] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 255, 15};

    longint m_cyc[4];
    int     m_quiet[4];
    bit     m_req[4], m_done[4], m_to[4];

    typedef struct {
        logic r, ia, iact;
        logic [1:0] st;
        logic dn, to;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    terminate_ctrl #(.DRAIN_CYCLES(4), .WATCHDOG_CYCLES(0), .CNT_W(32)) u0 (
        .clk(clk), .rst(rst), .a(a), .activity(activity),
        .done(dn_o[0]), .timeout(to_o[0]), .state(st_o[0]), .cycle_count(cc0));
    terminate_ctrl #(.DRAIN_CYCLES(3), .WATCHDOG_CYCLES(10), .CNT_W(32)) u1 (
        .clk(clk), .rst(rst), .a(a), .activity(activity),
        .done(dn_o[1]), .timeout(to_o[1]), .state(st_o[1]), .cycle_count(cc1));
    terminate_ctrl #(.DRAIN_CYCLES(0), .WATCHDOG_CYCLES(23), .CNT_W(8)) u2 (
        .clk(clk), .rst(rst), .a(a), .activity(activity),
        .done(dn_o[2]), .timeout(to_o[2]), .state(st_o[2]), .cycle_count(cc2));
    terminate_ctrl #(.DRAIN_CYCLES(2), .CNT_W(4)) u3 (
        .clk(clk), .rst(rst), .a(a), .activity(activity),
        .done(dn_o[3]), .timeout(to_o[3]), .state(st_o[3]), .cycle_count(cc3));

    assign cc_o[0] = cc0;
    assign cc_o[1] = cc1;
    assign cc_o[2] = {24'd0, cc2};
    assign cc_o[3] = {28'd0, cc3};

    task automatic cmp(input string name, input int i, input longint act, input longint exp);
        vec++;
        if (act != exp) begin
            miss++;
            $display("FAIL %s[u%0d] t=%0t: got %0d, want %0d", name, i, $time, act, exp);
        end
    endtask

    // Termination = request seen, then more than DRAIN_CYCLES consecutive quiet edges; or the budget is reached.
    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            longint nxt;
            bit grace, wd;
            if (m_done[i]) continue;
            nxt = m_cyc[i] < P_MAX[i] ? m_cyc[i] + 1 : m_cyc[i];
            grace = 0;
            if (!m_req[i]) begin
                if (a) begin
                    m_req[i] = 1;
                    m_quiet[i] = 0;
                end
            end else if (activity) m_quiet[i] = 0;
            else begin
                m_quiet[i]++;
                grace = m_quiet[i] > P_D[i];
            end
            wd = P_WD[i] != 0 && nxt == P_WD[i];
            m_cyc[i] = nxt;
            if (grace || wd) begin
                m_done[i] = 1;
                m_to[i] = !grace;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cyc[i] = 0;
            m_quiet[i] = 0;
            m_req[i] = 0;
            m_done[i] = 0;
            m_to[i] = 0;
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            cmp("state", i, st_o[i], m_done[i] ? 2 : (m_req[i] ? 1 : 0));
            cmp("done", i, dn_o[i], m_done[i]);
            cmp("timeout", i, to_o[i], m_to[i]);
            cmp("cycle_count", i, cc_o[i], m_cyc[i]);
        end
    endtask

    task automatic step(input logic ia, input logic iact);
        a = ia;
        activity = iact;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // asserts reset away from any edge and checks outputs clear before the next edge
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        #2;
        rst = 1'b0;
        a = 1'b0;
        activity = 1'b0;
    endtask

    function automatic void row(input logic r, input logic ia, input logic iact,
                                input logic [1:0] s, input logic d, input logic t);
        vec_t v;
        v.r = r; v.ia = ia; v.iact = iact; v.st = s; v.dn = d; v.to = t;
        tbl.push_back(v);
    endfunction

    initial begin
        // u0 (DRAIN_CYCLES=4, no watchdog): single-cycle request, then activity reload
        row(1, 0, 0, 0, 0, 0);
        row(0, 1, 0, 1, 0, 0);
        for (int k = 0; k < 4; k++) row(0, 0, 0, 1, 0, 0);
        row(0, 0, 0, 2, 1, 0);
        row(1, 0, 0, 0, 0, 0);
        row(0, 1, 0, 1, 0, 0);
        row(0, 0, 0, 1, 0, 0);
        row(0, 0, 0, 1, 0, 0);
        row(0, 1, 1, 1, 0, 0);
        for (int k = 0; k < 4; k++) row(0, 0, 0, 1, 0, 0);
        row(0, 0, 0, 2, 1, 0);
        row(0, 1, 1, 2, 1, 0);

        #2;
        foreach (tbl[k]) begin
            if (tbl[k].r) do_reset();
            else step(tbl[k].ia, tbl[k].iact);
            cmp("tbl_state", 0, st_o[0], tbl[k].st);
            cmp("tbl_done", 0, dn_o[0], tbl[k].dn);
            cmp("tbl_timeout", 0, to_o[0], tbl[k].to);
        end

        // watchdog with a tied low: u1 times out after 10 edges and freezes
        do_reset();
        repeat (9) step(0, 0);
        cmp("wd_early", 1, dn_o[1], 0);
        step(0, 0);
        cmp("wd_done", 1, dn_o[1], 1);
        cmp("wd_timeout", 1, to_o[1], 1);
        cmp("wd_cc", 1, cc_o[1], 10);
        repeat (3) step(1, 1);
        cmp("wd_frozen", 1, cc_o[1], 10);

        // graceful and watchdog on the same edge in u1; zero drain window in u2
        do_reset();
        repeat (5) step(0, 0);
        step(1, 0);
        cmp("d0_drain", 2, st_o[2], 1);
        step(0, 0);
        cmp("d0_done", 2, dn_o[2], 1);
        cmp("d0_timeout", 2, to_o[2], 0);
        step(0, 0);
        step(0, 0);
        cmp("tie_early", 1, dn_o[1], 0);
        step(0, 0);
        cmp("tie_done", 1, dn_o[1], 1);
        cmp("tie_timeout", 1, to_o[1], 0);
        cmp("tie_cc", 1, cc_o[1], 10);

        // long idle run: u0 stays in RUN, u3 saturates its 4-bit counter
        do_reset();
        repeat (1000) step(0, 0);
        cmp("idle_state", 0, st_o[0], 0);
        cmp("idle_done", 0, dn_o[0], 0);
        cmp("idle_cc", 0, cc_o[0], 1000);
        cmp("sat_cc", 3, cc_o[3], 15);
        cmp("wd23_cc", 2, cc_o[2], 23);

        // asynchronous reset mid-drain and in DONE, then a clean restart
        do_reset();
        step(1, 0);
        step(0, 0);
        do_reset();
        cmp("rst_drain_state", 0, st_o[0], 0);
        step(1, 0);
        repeat (5) step(0, 0);
        cmp("restart_done", 0, dn_o[0], 1);
        do_reset();
        cmp("rst_done_done", 0, dn_o[0], 0);
        step(1, 0);
        repeat (4) step(0, 0);
        cmp("restart2_early", 0, dn_o[0], 0);
        step(0, 0);
        cmp("restart2_done", 0, dn_o[0], 1);

        // random traffic with occasional resets
        do_reset();
        repeat (3000) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            else step($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule

// File: doc/terminate_ctrl.md
Name: terminate_ctrl

Overview:
- Simulation/system termination controller for the mesh tiles.
- Accepts a termination request `a`, waits for the network to go quiet (drain window), then raises a sticky `done`.
- A watchdog forces termination if the run exceeds a cycle budget.
- One instance per tile. Tiles that never request termination tie `a` to 0.

Parameters:
- DRAIN_CYCLES, 16: idle cycles required after a request before `done`.
- WATCHDOG_CYCLES, 1000000: cycle budget before forced termination; 0 disables the watchdog.
- CNT_W, 32: width of the cycle counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- a  input  1  termination request; level-sampled, latched on the first sampled 1
- activity  input  1  1 = traffic in flight; restarts the drain window
- done  output  1  sticky; terminated
- timeout  output  1  sticky; termination caused by the watchdog
- state  output  2  FSM state: 0 = RUN, 1 = DRAIN, 2 = DONE
- cycle_count  output  CNT_W  edges counted since reset release; frozen in DONE

Behaviour:
- Reset values (rst=1, asynchronous, overrides everything):
  - state=RUN, done=0, timeout=0, cycle_count=0, internal drain counter=0.
  - Reset mid-drain or in DONE fully restarts the block.
- cycle_count:
  - Increments by 1 on each edge in RUN or DRAIN.
  - Saturates at all-ones and never wraps.
  - Holds in DONE.
- RUN:
  - On an edge with a=1: go to DRAIN and load the drain counter with DRAIN_CYCLES.
  - a=0: stay in RUN.
- DRAIN:
  - The request is latched; deasserting `a` has no effect.
  - On each edge:
    - activity=1: reload the counter with DRAIN_CYCLES.
    - Otherwise, counter==0: go to DONE.
    - Otherwise: decrement the counter.
  - Net latency: with activity=0 throughout, done rises DRAIN_CYCLES+1 edges after the edge that sampled a=1.
  - DRAIN_CYCLES=0 gives done one edge after the sampling edge.
- Watchdog (WATCHDOG_CYCLES != 0):
  - On the edge where cycle_count would reach WATCHDOG_CYCLES while in RUN or DRAIN: go to DONE with timeout=1.
  - timeout therefore rises after WATCHDOG_CYCLES edges following reset release.
  - If graceful drain completion and the watchdog fire on the same edge, graceful wins: done=1, timeout=0.
- DONE:
  - Terminal until reset; done=1, timeout holds its value.
  - Inputs are ignored.
- Outputs are registered; no combinational path from inputs to outputs.
- a=0 permanently (the tied-off tile case): the block stays in RUN forever, or goes to DONE with timeout=1 if the watchdog is enabled.

Optional Feature:
- Macro: TERMINATE_CTRL_FINISH_EN.
- Defined:
  - On the edge entering DONE, print "[t=<time>] terminate: <graceful|timeout> cycles=<cycle_count>".
  - Call $finish on the following rising edge.
  - Simulation-only code.
- Undefined:
  - No system tasks are compiled.
  - The block is fully synthesizable; termination is signalled only via `done`/`timeout`.

Test Plan:
- Reset then a=1 for one cycle, activity=0, DRAIN_CYCLES=4 -> state goes to DRAIN on that edge; done=1 exactly 5 edges later; timeout=0.
- DRAIN_CYCLES=4, a=1, activity pulsed 1 on the 3rd DRAIN edge -> counter reloads; done rises 5 edges after the last activity edge.
- a=0 forever, WATCHDOG_CYCLES=10 -> done=1 and timeout=1 after 10 edges; cycle_count frozen at 10.
- WATCHDOG_CYCLES=0, a=0 for 1000 cycles -> state stays RUN, done=0, cycle_count=1000.
- rst asserted asynchronously mid-DRAIN and again in DONE -> all outputs return to 0 immediately (no clock edge); the sequence restarts correctly after release.
- Graceful completion and watchdog on the same edge (DRAIN_CYCLES=3, a=1 at edge 6, WATCHDOG_CYCLES=10) -> done=1, timeout=0.
